// File: rtl/encode_pkg.sv
// encode_pkg: shared definitions for the encode job sequencer.
//   state_e    - sequencer FSM states
//   NCORE_MAX  - largest supported core bundle (sets the remainder width)
//   LAT_W      - width of the FIN/STRM latency down-counter (latencies 1..7)
//   xs32_step  - one xorshift32 (13,17,5) step
package encode_pkg;

   localparam int NCORE_MAX = 32;
   localparam int LAT_W     = 3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RUN  = 3'd1,
      ST_FIN  = 3'd2,
      ST_STRM = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   function automatic logic [31:0] xs32_step(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

endpackage

// File: rtl/rand_gen.sv
// rand_gen: xorshift32 register used as the tie-break random word.
// Only compiled when ENCODE_SEQ_RAND_EN is defined.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (value clears to 0)
//   load      - load load_val this cycle (takes priority over adv)
//   load_val  - seed value to load (caller guarantees non-zero)
//   adv       - advance one xorshift32 step this cycle
//   value     - current generator state
`ifdef ENCODE_SEQ_RAND_EN
module rand_gen
   import encode_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        adv,
   output logic [31:0] value
);

   logic [31:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = load_val;
      end else if (adv) begin
         state_d = xs32_step(state_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   assign value = state_q;

endmodule
`endif

// File: rtl/encode_seq.sv
// encode_seq: encode job sequencer feeding the sign-bit buffer controller.
// Accepts a job (num_items, seed), turns core_valid handshakes into update
// pulses (last_update on the final one), then emits get_fin and stream_v at
// fixed latencies and a one-cycle done pulse.
// Optional feature macro: ENCODE_SEQ_RAND_EN enables the xorshift32 tie-break
// generator on tmp_rand; without it tmp_rand is 0 and seed is unused.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start         - job request, accepted only in IDLE
//   num_items     - items in the job, sampled with start
//   seed          - RNG seed, sampled with start
//   core_valid    - all cores present a result this cycle
//   update        - accumulate pulse
//   last_update   - marks the final update
//   remainder     - num_items % NCORE for the current job
//   tmp_even      - ~num_items[0] for the current job
//   tmp_rand      - tie-break random word
//   get_fin       - sign bits final (one cycle)
//   stream_v      - capture to stream register (one cycle)
//   busy          - job in RUN/FIN/STRM
//   done          - completion pulse
module encode_seq
   import encode_pkg::*;
#(
   parameter int NCORE      = 4,
   parameter int FIN_LAT    = 1,
   parameter int STREAM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] num_items,
   input  logic [31:0] seed,
   input  logic        core_valid,
   output logic        update,
   output logic        last_update,
   output logic [4:0]  remainder,
   output logic        tmp_even,
   output logic [31:0] tmp_rand,
   output logic        get_fin,
   output logic        stream_v,
   output logic        busy,
   output logic        done
);

   localparam int REM_W = $clog2(NCORE_MAX);
   localparam int SH    = $clog2(NCORE);

   state_e           state_q, state_d;
   logic [15:0]      upd_left_q, upd_left_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   logic             update_q, update_d;
   logic             last_q, last_d;
   logic             get_fin_q, get_fin_d;
   logic             stream_v_q, stream_v_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic             even_q, even_d;
   logic             accept;
   logic [REM_W-1:0] rem_new;

   always_comb begin
      accept     = (state_q == ST_IDLE) && start;
      rem_new    = num_items[REM_W-1:0] & REM_W'(NCORE - 1);
      state_d    = state_q;
      upd_left_d = upd_left_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      even_d     = even_q;
      update_d   = 1'b0;
      last_d     = 1'b0;
      get_fin_d  = 1'b0;
      stream_v_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               rem_d      = rem_new;
               even_d     = ~num_items[0];
               // ceil(num_items/NCORE): whole bundles plus one partial if any
               upd_left_d = (num_items >> SH) + {15'd0, |rem_new};
               state_d    = (num_items == 16'd0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (core_valid && (upd_left_q != 16'd0)) begin
               update_d   = 1'b1;
               upd_left_d = upd_left_q - 16'd1;
               if (upd_left_q == 16'd1) begin
                  last_d  = 1'b1;
                  state_d = ST_FIN;
                  cnt_d   = LAT_W'(FIN_LAT);
               end
            end
         end
         ST_FIN: begin
            if (cnt_q == LAT_W'(1)) begin
               get_fin_d = 1'b1;
               state_d   = ST_STRM;
               cnt_d     = LAT_W'(STREAM_LAT);
            end else begin
               cnt_d = cnt_q - LAT_W'(1);
            end
         end
         ST_STRM: begin
            // Counts down through zero so DONE lands one cycle after stream_v.
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               stream_v_d = (cnt_q == LAT_W'(1));
               cnt_d      = cnt_q - LAT_W'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         upd_left_q <= '0;
         cnt_q      <= '0;
         update_q   <= 1'b0;
         last_q     <= 1'b0;
         get_fin_q  <= 1'b0;
         stream_v_q <= 1'b0;
         rem_q      <= '0;
         even_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         upd_left_q <= upd_left_d;
         cnt_q      <= cnt_d;
         update_q   <= update_d;
         last_q     <= last_d;
         get_fin_q  <= get_fin_d;
         stream_v_q <= stream_v_d;
         rem_q      <= rem_d;
         even_q     <= even_d;
      end
   end

`ifdef ENCODE_SEQ_RAND_EN
   rand_gen u_rand_gen (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val ((seed == 32'd0) ? 32'h1 : seed),
      .adv      (get_fin_q),
      .value    (tmp_rand)
   );
`else
   logic unused_seed;
   assign unused_seed = ^seed;
   assign tmp_rand    = '0;
`endif

   assign update      = update_q;
   assign last_update = last_q;
   assign get_fin     = get_fin_q;
   assign stream_v    = stream_v_q;
   assign remainder   = rem_q;
   assign tmp_even    = even_q;
   assign busy        = (state_q == ST_RUN) || (state_q == ST_FIN) || (state_q == ST_STRM);
   assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_encode_seq.sv
module tb_encode_seq;

   localparam int NCORE      = 4;
   localparam int FIN_LAT    = 1;
   localparam int STREAM_LAT = 1;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] num_items;
   logic [31:0] seed;
   logic        core_valid;
   logic        update;
   logic        last_update;
   logic [4:0]  remainder;
   logic        tmp_even;
   logic [31:0] tmp_rand;
   logic        get_fin;
   logic        stream_v;
   logic        busy;
   logic        done;

   encode_seq #(
      .NCORE      (NCORE),
      .FIN_LAT    (FIN_LAT),
      .STREAM_LAT (STREAM_LAT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_items   (num_items),
      .seed        (seed),
      .core_valid  (core_valid),
      .update      (update),
      .last_update (last_update),
      .remainder   (remainder),
      .tmp_even    (tmp_even),
      .tmp_rand    (tmp_rand),
      .get_fin     (get_fin),
      .stream_v    (stream_v),
      .busy        (busy),
      .done        (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_xs(input logic [31:0] x);
      logic [31:0] v;
      v = x;
      v = v ^ (v << 13);
      v = v ^ (v >> 17);
      v = v ^ (v << 5);
      return v;
   endfunction

   // ---------------- behavioural job model ----------------
   // A job is described by its accept cycle, the number of updates still
   // owed, and (once the final update is known) the absolute cycles of
   // get_fin, stream_v and done.
   int          cyc = 0;
   bit          m_valid = 0;
   bit          job = 0;
   int          t_acc, left, gf_cyc, sv_cyc, done_cyc;
   logic [4:0]  m_rem = '0;
   logic        m_even = 1'b0;
   logic [31:0] m_rand = '0;
   logic        e_update = 1'b0;
   logic        e_last = 1'b0;

   task automatic model_step();
      int n;
      n = cyc + 1;
      e_update = 1'b0;
      e_last   = 1'b0;
      if (rst) begin
         job = 0; m_rem = '0; m_even = 1'b0; m_rand = '0; m_valid = 1;
      end else if (m_valid) begin
         if (job && gf_cyc == cyc) m_rand = ref_xs(m_rand);
         if (job && cyc >= done_cyc) begin
            job = 0;              // done cycle: any start here is dropped
         end else if (!job) begin
            if (start) begin
               job    = 1;
               t_acc  = cyc;
               m_rem  = 5'(int'(num_items) % NCORE);
               m_even = ~num_items[0];
               left   = (int'(num_items) + NCORE - 1) / NCORE;
               m_rand = (seed == 0) ? 32'h1 : seed;
               gf_cyc = -10;
               sv_cyc = -10;
               done_cyc = (num_items == 0) ? n : 32'h3fffffff;
            end
         end else if (left > 0 && cyc > t_acc && core_valid) begin
            e_update = 1'b1;
            left--;
            if (left == 0) begin
               e_last   = 1'b1;
               gf_cyc   = n + FIN_LAT;
               sv_cyc   = gf_cyc + STREAM_LAT;
               done_cyc = sv_cyc + 1;
            end
         end
      end
      cyc = n;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- compare + monitor ----------------
   int          upd_cnt, last_cnt, gf_cnt, sv_cnt, done_cnt;
   int          first_upd_cyc, last_upd_cyc, gf_at, sv_at, done_at;
   logic [31:0] rand_at_last, rand_at_done;
   logic [4:0]  rem_at_done;
   logic        even_at_done;

   task automatic clr_mon();
      upd_cnt = 0; last_cnt = 0; gf_cnt = 0; sv_cnt = 0; done_cnt = 0;
      first_upd_cyc = -1; last_upd_cyc = -1; gf_at = -1; sv_at = -1; done_at = -1;
   endtask

   initial begin
      clr_mon();
      forever begin
         @(negedge clk);
         if (m_valid) begin
            chk("update",      update,      e_update);
            chk("last_update", last_update, e_last);
            chk("remainder",   remainder,   m_rem);
            chk("tmp_even",    tmp_even,    m_even);
`ifdef ENCODE_SEQ_RAND_EN
            chk("tmp_rand",    tmp_rand,    m_rand);
`else
            chk("tmp_rand",    tmp_rand,    32'h0);
`endif
            chk("get_fin",  get_fin,  job && cyc == gf_cyc);
            chk("stream_v", stream_v, job && cyc == sv_cyc);
            chk("busy",     busy,     job && cyc > t_acc && cyc < done_cyc);
            chk("done",     done,     job && cyc == done_cyc);
         end
         if (update) begin
            if (upd_cnt == 0) first_upd_cyc = cyc;
            upd_cnt++;
         end
         if (last_update) begin last_cnt++; last_upd_cyc = cyc; rand_at_last = tmp_rand; end
         if (get_fin)  begin gf_cnt++; gf_at = cyc; end
         if (stream_v) begin sv_cnt++; sv_at = cyc; end
         if (done) begin
            done_cnt++; done_at = cyc;
            rand_at_done = tmp_rand; rem_at_done = remainder; even_at_done = tmp_even;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (done_cnt == 0 && k < budget) begin
         tick();
         k++;
      end
      if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic launch(input logic [15:0] n, input logic [31:0] s);
      num_items = n;
      seed      = s;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   initial begin
      int t0, k;
      rst = 1'b1; start = 1'b0; num_items = '0; seed = '0; core_valid = 1'b0;
      tick(); tick();
      @(negedge clk);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_rem",  remainder, 5'd0);
      chk("reset_rand", tmp_rand, 32'h0);
      tick();
      rst = 1'b0;
      tick();

      // 10 items, core_valid held high
      clr_mon();
      core_valid = 1'b1;
      launch(16'd10, 32'd0);
      wait_done(40);
      core_valid = 1'b0;
      chk("A_updates", upd_cnt, 3);
      chk("A_last_cnt", last_cnt, 1);
      chk("A_consecutive", last_upd_cyc - first_upd_cyc, 2);
      chk("A_remainder", rem_at_done, 5'd2);
      chk("A_tmp_even", even_at_done, 1'b1);
      chk("A_get_fin_lat", gf_at - last_upd_cyc, 1);
      chk("A_stream_lat", sv_at - last_upd_cyc, 2);
      chk("A_done_lat", done_at - last_upd_cyc, 3);
`ifdef ENCODE_SEQ_RAND_EN
      chk("A_rand_run", rand_at_last, 32'h1);
      chk("A_rand_after", rand_at_done, 32'h00042021);
`else
      chk("A_rand_off", rand_at_done, 32'h0);
`endif

      // 8 items, core_valid toggling
      clr_mon();
      launch(16'd8, 32'h1234);
      k = 0;
      while (done_cnt == 0 && k < 60) begin
         core_valid = ~core_valid;
         tick();
         k++;
      end
      core_valid = 1'b0;
      if (done_cnt == 0) chk("B_timeout", 32'd0, 32'd1);
      chk("B_updates", upd_cnt, 2);
      chk("B_remainder", rem_at_done, 5'd0);
      chk("B_tmp_even", even_at_done, 1'b1);

      // zero items
      clr_mon();
      tick();
      t0 = cyc;
      launch(16'd0, 32'd7);
      wait_done(10);
      chk("Z_done_lat", done_at - t0, 1);
      chk("Z_updates", upd_cnt, 0);
      chk("Z_get_fin", gf_cnt, 0);
      chk("Z_stream", sv_cnt, 0);

      // reset after second of three updates
      tick();
      clr_mon();
      core_valid = 1'b1;
      launch(16'd12, 32'd9);
      k = 0;
      while (upd_cnt < 2 && k < 20) begin tick(); k++; end
      if (upd_cnt < 2) chk("R_timeout", 32'd0, 32'd1);
      rst = 1'b1;
      core_valid = 1'b0;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("R_busy", busy, 1'b0);
      chk("R_update", update, 1'b0);
      chk("R_rem", remainder, 5'd0);
      chk("R_done", done, 1'b0);
      clr_mon();
      repeat (10) tick();
      chk("R_no_done", done_cnt, 0);
      core_valid = 1'b1;
      launch(16'd5, 32'd3);
      wait_done(40);
      core_valid = 1'b0;
      chk("R2_updates", upd_cnt, 2);
      chk("R2_remainder", rem_at_done, 5'd1);
      chk("R2_tmp_even", even_at_done, 1'b0);

      // start during RUN is ignored
      tick();
      clr_mon();
      launch(16'd16, 32'd5);
      k = 0;
      while (done_cnt == 0 && k < 80) begin
         core_valid = (k % 3 == 0);
         start      = (k == 4);
         if (k == 4) num_items = 16'd3;
         tick();
         k++;
      end
      start = 1'b0; core_valid = 1'b0;
      if (done_cnt == 0) chk("S_timeout", 32'd0, 32'd1);
      chk("S_updates", upd_cnt, 4);
      chk("S_remainder", rem_at_done, 5'd0);
      chk("S_done_cnt", done_cnt, 1);

      // randomized traffic checked cycle by cycle against the model
      for (int i = 0; i < 3000; i++) begin
         start      = ($urandom % 6) == 0;
         num_items  = (($urandom % 4) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 30));
         seed       = (($urandom % 8) == 0) ? 32'd0 : $urandom;
         core_valid = ($urandom % 3) != 0;
         rst        = ($urandom % 300) == 0;
         tick();
      end
      rst = 1'b0; start = 1'b0; core_valid = 1'b0;
      repeat (5) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
